// File: rtl/decode.sv
// RV32I decode stage: pops one {pc, insn} entry per cycle from the instruction FIFO
// and presents a registered decode packet to dispatch with a valid/stall handshake.
module decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             i_flush,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_insn_fifo_data,
  input  logic                             i_insn_fifo_empty,
  output logic                             o_insn_fifo_rd_en,
  input  logic                             i_stall,
  output logic                             o_valid,
  output logic [ADDR_WIDTH-1:0]            o_pc,
  output logic [3:0]                       o_class,
  output logic [2:0]                       o_funct3,
  output logic                             o_funct7b5,
  output logic [4:0]                       o_rdest,
  output logic [4:0]                       o_rsrc1,
  output logic [4:0]                       o_rsrc2,
  output logic                             o_rdest_en,
  output logic                             o_rsrc1_en,
  output logic                             o_rsrc2_en,
  output logic [DATA_WIDTH-1:0]            o_imm
);

  typedef enum logic [3:0] {
    CLASS_LUI     = 4'd0,
    CLASS_AUIPC   = 4'd1,
    CLASS_JAL     = 4'd2,
    CLASS_JALR    = 4'd3,
    CLASS_BRANCH  = 4'd4,
    CLASS_LOAD    = 4'd5,
    CLASS_STORE   = 4'd6,
    CLASS_OPIMM   = 4'd7,
    CLASS_OP      = 4'd8,
    CLASS_ILLEGAL = 4'd15
  } insnClass_e;

  logic [ADDR_WIDTH-1:0] w_pc;
  logic [31:0]           w_insn;
  logic [6:0]            w_opcode;
  logic                  w_load;
  logic                  w_pop;
  insnClass_e            w_class;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_rdestUse;
  logic                  w_rdestEn;
  logic                  w_rsrc1En;
  logic                  w_rsrc2En;

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [3:0]            r_class;
  logic [2:0]            r_funct3;
  logic                  r_funct7b5;
  logic [4:0]            r_rdest;
  logic [4:0]            r_rsrc1;
  logic [4:0]            r_rsrc2;
  logic                  r_rdestEn;
  logic                  r_rsrc1En;
  logic                  r_rsrc2En;
  logic [DATA_WIDTH-1:0] r_imm;

  assign w_pc     = i_insn_fifo_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign w_insn   = i_insn_fifo_data[31:0];
  assign w_opcode = w_insn[6:0];

  // The pop is gated by reset too, so nothing is consumed while the stage is held in reset.
  assign w_load = ~r_valid | ~i_stall;
  assign w_pop  = n_rst & ~i_insn_fifo_empty & ~i_flush & w_load;
  assign o_insn_fifo_rd_en = w_pop;

  always_comb begin
    w_class    = CLASS_ILLEGAL;
    w_imm      = '0;
    w_rdestUse = 1'b0;
    w_rsrc1En  = 1'b0;
    w_rsrc2En  = 1'b0;
    case (w_opcode)
      7'b0110111: begin
        w_class    = CLASS_LUI;
        w_imm      = DATA_WIDTH'($signed({w_insn[31:12], 12'b0}));
        w_rdestUse = 1'b1;
      end
      7'b0010111: begin
        w_class    = CLASS_AUIPC;
        w_imm      = DATA_WIDTH'($signed({w_insn[31:12], 12'b0}));
        w_rdestUse = 1'b1;
      end
      7'b1101111: begin
        w_class    = CLASS_JAL;
        w_imm      = DATA_WIDTH'($signed({w_insn[31], w_insn[19:12], w_insn[20], w_insn[30:21], 1'b0}));
        w_rdestUse = 1'b1;
      end
      7'b1100111: begin
        w_class    = CLASS_JALR;
        w_imm      = DATA_WIDTH'($signed(w_insn[31:20]));
        w_rdestUse = 1'b1;
        w_rsrc1En  = 1'b1;
      end
      7'b1100011: begin
        w_class   = CLASS_BRANCH;
        w_imm     = DATA_WIDTH'($signed({w_insn[31], w_insn[7], w_insn[30:25], w_insn[11:8], 1'b0}));
        w_rsrc1En = 1'b1;
        w_rsrc2En = 1'b1;
      end
      7'b0000011: begin
        w_class    = CLASS_LOAD;
        w_imm      = DATA_WIDTH'($signed(w_insn[31:20]));
        w_rdestUse = 1'b1;
        w_rsrc1En  = 1'b1;
      end
      7'b0100011: begin
        w_class   = CLASS_STORE;
        w_imm     = DATA_WIDTH'($signed({w_insn[31:25], w_insn[11:7]}));
        w_rsrc1En = 1'b1;
        w_rsrc2En = 1'b1;
      end
      7'b0010011: begin
        w_class    = CLASS_OPIMM;
        w_imm      = DATA_WIDTH'($signed(w_insn[31:20]));
        w_rdestUse = 1'b1;
        w_rsrc1En  = 1'b1;
      end
      7'b0110011: begin
        w_class    = CLASS_OP;
        w_rdestUse = 1'b1;
        w_rsrc1En  = 1'b1;
        w_rsrc2En  = 1'b1;
      end
      default: begin
        w_class = CLASS_ILLEGAL;
      end
    endcase
  end

  // Writes to x0 are architecturally discarded, so rename should not allocate for them.
  assign w_rdestEn = w_rdestUse & (|w_insn[11:7]);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_class    <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rdest    <= '0;
      r_rsrc1    <= '0;
      r_rsrc2    <= '0;
      r_rdestEn  <= 1'b0;
      r_rsrc1En  <= 1'b0;
      r_rsrc2En  <= 1'b0;
      r_imm      <= '0;
    end else if (w_pop) begin
      r_valid    <= 1'b1;
      r_pc       <= w_pc;
      r_class    <= w_class;
      r_funct3   <= w_insn[14:12];
      r_funct7b5 <= w_insn[30];
      r_rdest    <= w_insn[11:7];
      r_rsrc1    <= w_insn[19:15];
      r_rsrc2    <= w_insn[24:20];
      r_rdestEn  <= w_rdestEn;
      r_rsrc1En  <= w_rsrc1En;
      r_rsrc2En  <= w_rsrc2En;
      r_imm      <= w_imm;
    end else if (w_load || i_flush) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_class    = r_class;
  assign o_funct3   = r_funct3;
  assign o_funct7b5 = r_funct7b5;
  assign o_rdest    = r_rdest;
  assign o_rsrc1    = r_rsrc1;
  assign o_rsrc2    = r_rsrc2;
  assign o_rdest_en = r_rdestEn;
  assign o_rsrc1_en = r_rsrc1En;
  assign o_rsrc2_en = r_rsrc2En;
  assign o_imm      = r_imm;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus randomized traffic against
// a queue-based FIFO model and an arithmetic RV32I reference decoder.
module tb_decode;

  logic        clk;
  logic        n_rst;
  logic        i_flush;
  logic [63:0] i_insn_fifo_data;
  logic        i_insn_fifo_empty;
  logic        o_insn_fifo_rd_en;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [3:0]  o_class;
  logic [2:0]  o_funct3;
  logic        o_funct7b5;
  logic [4:0]  o_rdest;
  logic [4:0]  o_rsrc1;
  logic [4:0]  o_rsrc2;
  logic        o_rdest_en;
  logic        o_rsrc1_en;
  logic        o_rsrc2_en;
  logic [31:0] o_imm;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rdEn;
    logic        rs1En;
    logic        rs2En;
    logic [31:0] imm;
  } pkt_t;

  logic [63:0] fifoQ[$];
  pkt_t        expPkt;
  bit          chkAll;
  int          total;
  int          bad;
  logic [31:0] nextPc;

  decode dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .i_flush           (i_flush),
    .i_insn_fifo_data  (i_insn_fifo_data),
    .i_insn_fifo_empty (i_insn_fifo_empty),
    .o_insn_fifo_rd_en (o_insn_fifo_rd_en),
    .i_stall           (i_stall),
    .o_valid           (o_valid),
    .o_pc              (o_pc),
    .o_class           (o_class),
    .o_funct3          (o_funct3),
    .o_funct7b5        (o_funct7b5),
    .o_rdest           (o_rdest),
    .o_rsrc1           (o_rsrc1),
    .o_rsrc2           (o_rsrc2),
    .o_rdest_en        (o_rdest_en),
    .o_rsrc1_en        (o_rsrc1_en),
    .o_rsrc2_en        (o_rsrc2_en),
    .o_imm             (o_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Immediates are rebuilt as signed sums of their bit fields rather than by concatenation.
  function automatic pkt_t refDecode(input logic [63:0] e);
    pkt_t        p;
    logic [31:0] x;
    int          s;
    int          v;
    x = e[31:0];
    s = x[31] ? 1 : 0;
    v = 0;
    p = '0;
    p.valid = 1'b1;
    p.pc  = e[63:32];
    p.f3  = x[14:12];
    p.f7  = x[30];
    p.rd  = x[11:7];
    p.rs1 = x[19:15];
    p.rs2 = x[24:20];
    case (x[6:0])
      7'h37:   p.cls = 4'd0;
      7'h17:   p.cls = 4'd1;
      7'h6F:   p.cls = 4'd2;
      7'h67:   p.cls = 4'd3;
      7'h63:   p.cls = 4'd4;
      7'h03:   p.cls = 4'd5;
      7'h23:   p.cls = 4'd6;
      7'h13:   p.cls = 4'd7;
      7'h33:   p.cls = 4'd8;
      default: p.cls = 4'd15;
    endcase
    case (p.cls)
      4'd3, 4'd5, 4'd7: v = int'(x[30:20]) - s * 2048;
      4'd6: v = int'(x[30:25]) * 32 + int'(x[11:7]) - s * 2048;
      4'd4: v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2 - s * 4096;
      4'd2: v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2 - s * 1048576;
      default: v = 0;
    endcase
    p.imm = (p.cls inside {4'd0, 4'd1}) ? (x & 32'hFFFFF000) : 32'(v);
    p.rdEn  = (p.cls inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8}) && (x[11:7] != 5'd0);
    p.rs1En = p.cls inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    p.rs2En = p.cls inside {4'd4, 4'd6, 4'd8};
    return p;
  endfunction

  task automatic compareAll();
    checkOutput("valid", 64'(o_valid), 64'(expPkt.valid));
    if (expPkt.valid || chkAll) begin
      checkOutput("pc", 64'(o_pc), 64'(expPkt.pc));
      checkOutput("class", 64'(o_class), 64'(expPkt.cls));
      checkOutput("funct3", 64'(o_funct3), 64'(expPkt.f3));
      checkOutput("funct7b5", 64'(o_funct7b5), 64'(expPkt.f7));
      checkOutput("rdest", 64'(o_rdest), 64'(expPkt.rd));
      checkOutput("rsrc1", 64'(o_rsrc1), 64'(expPkt.rs1));
      checkOutput("rsrc2", 64'(o_rsrc2), 64'(expPkt.rs2));
      checkOutput("rdest_en", 64'(o_rdest_en), 64'(expPkt.rdEn));
      checkOutput("rsrc1_en", 64'(o_rsrc1_en), 64'(expPkt.rs1En));
      checkOutput("rsrc2_en", 64'(o_rsrc2_en), 64'(expPkt.rs2En));
      checkOutput("imm", 64'(o_imm), 64'(expPkt.imm));
    end
  endtask

  // One clock cycle: drive at negedge, check the pop request, advance the model at posedge,
  // then check the registered packet.
  task automatic applyStimulus(input bit rst, input bit flush, input bit stall);
    bit expRd;
    @(negedge clk);
    n_rst             = ~rst;
    i_flush           = flush;
    i_stall           = stall;
    i_insn_fifo_empty = (fifoQ.size() == 0);
    i_insn_fifo_data  = (fifoQ.size() == 0) ? 64'h0 : fifoQ[0];
    #1;
    expRd = !rst && (fifoQ.size() != 0) && !flush && (!expPkt.valid || !stall);
    checkOutput("rd_en", 64'(o_insn_fifo_rd_en), 64'(expRd));
    @(posedge clk);
    chkAll = rst;
    if (rst) begin
      expPkt = '0;
    end else if (expRd) begin
      expPkt = refDecode(fifoQ.pop_front());
    end else if (!expPkt.valid || !stall || flush) begin
      expPkt.valid = 1'b0;
    end
    if (!rst && flush) fifoQ.delete();
    #1;
    compareAll();
  endtask

  task automatic pushInsn(input logic [31:0] insn);
    fifoQ.push_back({nextPc, insn});
    nextPc += 32'd4;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (fifoQ.size() != 0 || expPkt.valid); i++) applyStimulus(0, 0, 0);
    checkOutput("drained", 64'(fifoQ.size() == 0 && !o_valid), 64'd1);
  endtask

  initial begin
    logic [6:0]  opTable [9];
    logic [31:0] r;
    total = 0;
    bad = 0;
    expPkt = '0;
    chkAll = 1'b0;
    nextPc = 32'h0000_2000;
    n_rst = 1'b0;
    i_flush = 1'b0;
    i_stall = 1'b0;
    i_insn_fifo_empty = 1'b1;
    i_insn_fifo_data = '0;
    opTable = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);

    // addi x1, x0, 5
    fifoQ.push_back({32'h0000_1000, 32'h0050_0093});
    applyStimulus(0, 0, 0);
    checkOutput("t1_pc", 64'(o_pc), 64'h1000);
    checkOutput("t1_class", 64'(o_class), 64'd7);
    checkOutput("t1_imm", 64'(o_imm), 64'h5);
    checkOutput("t1_en", 64'({o_rdest_en, o_rsrc1_en, o_rsrc2_en}), 64'b110);
    drain();

    pushInsn(32'h0020_8133);
    pushInsn(32'h0041_2183);
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("t2_second_pc", 64'(o_pc), 64'h2004);
    drain();

    pushInsn(32'hFE00_0EE3);
    pushInsn(32'hFF9F_F0EF);
    pushInsn(32'h1234_50B7);
    applyStimulus(0, 0, 0);
    checkOutput("t3_b_imm", 64'(o_imm), 64'hFFFF_FFFC);
    checkOutput("t3_b_rden", 64'(o_rdest_en), 64'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_j_imm", 64'(o_imm), 64'hFFFF_FFF8);
    checkOutput("t3_j_rd", 64'(o_rdest), 64'd1);
    applyStimulus(0, 0, 0);
    checkOutput("t3_u_imm", 64'(o_imm), 64'h1234_5000);
    drain();

    pushInsn(32'h0050_0093);
    pushInsn(32'h0060_0113);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("t4_flush_valid", 64'(o_valid), 64'd0);
    drain();

    pushInsn(32'h0000_0000);
    pushInsn(32'h0000_0073);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("t5_class", 64'(o_class), 64'd15);
      checkOutput("t5_en_imm", 64'({o_rdest_en, o_rsrc1_en, o_rsrc2_en, o_imm}), 64'd0);
    end
    drain();

    pushInsn(32'h0010_0093);
    pushInsn(32'h0020_0113);
    pushInsn(32'h0030_0193);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 1);
    checkOutput("t6_rst_valid", 64'(o_valid), 64'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t6_resume_pc", 64'(o_pc), nextPc - 64'd8);
    drain();

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 60 && fifoQ.size() < 6) begin
        r = $urandom();
        if ($urandom_range(0, 9) != 0) r[6:0] = opTable[$urandom_range(0, 8)];
        pushInsn(r);
      end
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 30);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

In-order decode stage that drains the instruction FIFO filled by the fetch unit. It pops one `{pc, insn}` entry per cycle, decodes it as RV32I into a registered decode packet, and presents the packet to the rename/dispatch stage with a valid/stall handshake. It sits between the instruction FIFO read port and dispatch, and discards all in-flight work on a pipeline redirect.

## Interface
- `ADDR_WIDTH`, 32: PC width (`procyon_addr_t`).
- `DATA_WIDTH`, 32: instruction width (`procyon_data_t`).
- `clk` in 1: clock.
- `n_rst` in 1: synchronous, active-low reset.
- `i_flush` in 1: redirect/flush; kills the output packet and blocks the FIFO pop this cycle.
- `i_insn_fifo_data` in 64: `procyon_addr_data_t`; PC in [63:32], instruction in [31:0]; show-ahead, valid whenever not empty.
- `i_insn_fifo_empty` in 1: FIFO empty.
- `o_insn_fifo_rd_en` in/out: out 1; pop the head entry at this clock edge.
- `i_stall` in 1: dispatch cannot accept the current packet.
- `o_valid` out 1: decode packet valid.
- `o_pc` out 32: PC of the decoded instruction.
- `o_class` out 4: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 15 ILLEGAL.
- `o_funct3` out 3: insn[14:12].
- `o_funct7b5` out 1: insn[30].
- `o_rdest`, `o_rsrc1`, `o_rsrc2` out 5 each: insn[11:7], insn[19:15], insn[24:20].
- `o_rdest_en`, `o_rsrc1_en`, `o_rsrc2_en` out 1 each: register-use flags.
- `o_imm` out 32: sign-extended immediate.

## Operation
- Accept condition: `load = ~o_valid | ~i_stall`.
- Pop rule: `o_insn_fifo_rd_en = ~i_insn_fifo_empty & ~i_flush & load`.
- Output register update:
  - On pop, capture the decoded packet and set `o_valid`=1.
  - With `load` true and no pop, set `o_valid`=0.
  - With `load` false, hold all outputs.
- Immediate formats:
  - I (JALR, LOAD, OP_IMM): sext(insn[31:20]).
  - S: sext({insn[31:25], insn[11:7]}).
  - B: sext({insn[31], insn[7], insn[30:25], insn[11:8], 0}).
  - U (LUI, AUIPC): {insn[31:12], 12'b0}.
  - J: sext({insn[31], insn[19:12], insn[20], insn[30:21], 0}).
  - OP: `o_imm` = 0.
- Register-use flags:
  - `rdest_en`: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and only when rd≠0.
  - `rsrc1_en`: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - `rsrc2_en`: BRANCH, STORE, OP.
- Illegal instructions:
  - ILLEGAL when insn[1:0]≠2'b11 or the opcode is not one of the nine supported opcodes.
  - An ILLEGAL packet is still issued with `o_valid`=1 so the ROB traps.
  - For ILLEGAL, all `_en` flags are 0 and `o_imm` = 0.
- `funct3`/`funct7` are not checked here; the execute units handle them.

## Timing
- Reset (`n_rst`=0 at a clock edge): every output register clears to 0 (`o_valid`=0, `o_class`=0). `o_insn_fifo_rd_en` is combinational and forced to 0 while in reset. Reset mid-stream drops the held packet and pops nothing.
- Latency: an entry popped at edge N is on the outputs, with `o_valid`=1, during cycle N+1.
- Throughput: 1 instruction/cycle with FIFO non-empty and `i_stall`=0.
- Stall: with `o_valid`=1 and `i_stall`=1, outputs are held bit-stable and `rd_en`=0. With `o_valid`=0, `i_stall` is ignored (bubble is filled).
- Flush:
  - `i_flush`=1 gives `rd_en`=0 in the same cycle and `o_valid`=0 next cycle, regardless of `i_stall`.
  - The FIFO is flushed externally by the same signal.
- Flush and stall together: flush wins.
- FIFO empty: no pop; `o_valid` falls after the current packet is accepted.
- Ordering: no entry is dropped or duplicated except on flush or reset.

## Test plan
1. FIFO head {0x00001000, 0x00500093} (addi x1,x0,5), `i_stall`=0 -> `rd_en`=1 cycle 0. Cycle 1:
   - `o_valid`=1, `o_pc`=0x1000, class 7;
   - rdest 1, `rdest_en`=1, `rsrc1_en`=1, `rsrc2_en`=0, imm 0x00000005.
2. Back-to-back stall: two entries queued, `i_stall`=1 once the first is valid -> `rd_en`=0 and outputs unchanged for 3 cycles. Drop `i_stall` -> second packet appears the next cycle.
3. Immediates:
   - 0xFE000EE3 -> class 4, imm 0xFFFFFFFC, `rdest_en`=0;
   - 0xFF9FF0EF -> class 2, imm 0xFFFFFFF8, rdest 1;
   - 0x123450B7 -> class 0, imm 0x12345000.
4. Flush with `o_valid`=1, `i_stall`=1, FIFO non-empty -> `rd_en`=0 that cycle and `o_valid`=0 next cycle.
5. Illegal 0x00000000 and 0x00000073 -> `o_valid`=1, class 15, all `_en`=0, imm 0.
6. Assert `n_rst`=0 mid-stream with `o_valid`=1 -> next cycle all outputs 0 and no pop. After release, decode resumes from the FIFO head.
